// File: rtl/ex_mem_skid.sv
// ex_mem_skid: EX->MEM pipeline register with a 2-entry skid buffer.
// HEAD drives the MEM stage from flops; SKID absorbs one result during a dcache stall.
module ex_mem_skid #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              ex_valid_i,
   output logic              ex_ready_o,
   input  logic [DATA_W-1:0] ex_alu_i,
   input  logic [DATA_W-1:0] ex_rs2_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic [3:0]        ex_ctrl_i,
   output logic              mem_valid_o,
   input  logic              mem_ready_i,
   output logic [DATA_W-1:0] mem_alu_o,
   output logic [DATA_W-1:0] mem_rs2_o,
   output logic [REG_AW-1:0] mem_rd_o,
   output logic [3:0]        mem_ctrl_o,
   output logic [1:0]        level_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);
   localparam int PW = 2*DATA_W + REG_AW + 4;
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_skid;
   logic             r_hv;
   logic             r_sv;
   logic             r_ready;
   logic [CNT_W-1:0] r_cnt;
   logic [PW-1:0]    w_in;
   logic [3:0]       w_ctrl;
   logic             w_acc;
   logic             w_deq;
   logic             w_head_in;
   logic             w_head_skid;
   logic             w_skid_ld;
   logic             w_hv_n;
   logic             w_sv_n;
   assign w_in = {ex_ctrl_i, ex_rd_i, ex_rs2_i, ex_alu_i};
   // SKID can only hold data while ex_ready_o is low, so the two HEAD load sources never collide
   always_comb begin
      w_acc       = ex_valid_i & r_ready;
      w_deq       = r_hv & mem_ready_i;
      w_head_in   = ~flush_i & w_acc & (~r_hv | w_deq);
      w_head_skid = ~flush_i & r_sv & w_deq;
      w_skid_ld   = ~flush_i & w_acc & r_hv & ~w_deq;
      w_hv_n      = ~flush_i & (r_sv | w_acc | (r_hv & ~w_deq));
      w_sv_n      = ~flush_i & ((r_sv & ~w_deq) | w_skid_ld);
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_head  <= '0;
         r_skid  <= '0;
         r_hv    <= 1'b0;
         r_sv    <= 1'b0;
         r_ready <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_hv    <= w_hv_n;
         r_sv    <= w_sv_n;
         r_ready <= ~w_sv_n;
         if (w_head_in) r_head <= w_in;
         else if (w_head_skid) r_head <= r_skid;
         if (w_skid_ld) r_skid <= w_in;
         if (r_hv & ~mem_ready_i & ~&r_cnt) r_cnt <= r_cnt + CNT_W'(1);
      end
   end
   assign {w_ctrl, mem_rd_o, mem_rs2_o, mem_alu_o} = r_head;
   assign mem_ctrl_o  = r_hv ? w_ctrl : 4'b0;
   assign mem_valid_o = r_hv;
   assign ex_ready_o  = r_ready;
   assign level_o     = {r_hv & r_sv, r_hv ^ r_sv};
   assign stall_cnt_o = r_cnt;
endmodule

// File: tb/tb_ex_mem_skid.sv
// tb_ex_mem_skid: directed vector table, multi-cycle corner sequences and a random scoreboard run.
module tb_ex_mem_skid;
   logic        clk;
   logic        rst;
   logic        flush;
   logic        ev;
   logic        rdy;
   logic [31:0] alu;
   logic [31:0] rs2;
   logic [4:0]  rd;
   logic [3:0]  ctrl;
   logic        mv;
   logic        mr;
   logic [31:0] m_alu;
   logic [31:0] m_rs2;
   logic [4:0]  m_rd;
   logic [3:0]  m_ctrl;
   logic [1:0]  lvl;
   logic [15:0] cnt;
   logic        s_rdy;
   logic        s_mv;
   logic [31:0] s_alu;
   logic [31:0] s_rs2;
   logic [4:0]  s_rd;
   logic [3:0]  s_ctrl;
   logic [1:0]  s_lvl;
   logic [1:0]  s_cnt;
   int n_pass = 0;
   int n_tot  = 0;

   ex_mem_skid dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .ex_valid_i(ev), .ex_ready_o(rdy),
      .ex_alu_i(alu), .ex_rs2_i(rs2), .ex_rd_i(rd), .ex_ctrl_i(ctrl),
      .mem_valid_o(mv), .mem_ready_i(mr), .mem_alu_o(m_alu), .mem_rs2_o(m_rs2),
      .mem_rd_o(m_rd), .mem_ctrl_o(m_ctrl), .level_o(lvl), .stall_cnt_o(cnt)
   );
   ex_mem_skid #(.CNT_W(2)) u_small (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .ex_valid_i(ev), .ex_ready_o(s_rdy),
      .ex_alu_i(alu), .ex_rs2_i(rs2), .ex_rd_i(rd), .ex_ctrl_i(ctrl),
      .mem_valid_o(s_mv), .mem_ready_i(mr), .mem_alu_o(s_alu), .mem_rs2_o(s_rs2),
      .mem_rd_o(s_rd), .mem_ctrl_o(s_ctrl), .level_o(s_lvl), .stall_cnt_o(s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ev, mr, fl;
      logic [31:0] alu;
      logic [3:0]  ctrl;
      logic        e_mv;
      logic [31:0] e_alu;
      logic [3:0]  e_ctrl;
      logic [1:0]  e_lvl;
      logic        e_rdy;
   } vec_t;
   vec_t tbl[13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // stimulus payload: rs2 and rd are derived from alu so one number identifies an entry
   task automatic drive(input logic v, input logic [31:0] a, input logic [3:0] c);
      ev   = v;
      alu  = a;
      rs2  = a ^ 32'h5A5A_5A5A;
      rd   = a[4:0];
      ctrl = c;
   endtask

   logic [72:0] q[$];
   logic [72:0] pl;
   logic [15:0] m_cnt;

   initial begin
      rst = 1'b0; flush = 1'b0; mr = 1'b1;
      drive(1'b0, 32'h0, 4'h0);
      #12;
      chk("reset", {95'b0, mv, m_alu, m_rs2, m_rd, m_ctrl, lvl, rdy, cnt},
          {95'b0, 1'b0, 32'h0, 32'h0, 5'h0, 4'h0, 2'd0, 1'b1, 16'd0});
      @(negedge clk);
      rst = 1'b1;
      tick();
      //             ev    mr    fl    alu           ctrl   mv    alu           ctrl   lvl   rdy
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h1,        4'hF, 1'b1, 32'h1,        4'hF, 2'd1, 1'b1};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h20,       4'hF, 1'b1, 32'h20,       4'hF, 2'd1, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFD, 4'h9, 1'b1, 32'hFFFFFFFD, 4'h9, 2'd1, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'hA,        4'h8, 1'b1, 32'hA,        4'h8, 2'd1, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'hB,        4'h2, 1'b1, 32'hA,        4'h8, 2'd2, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'hC,        4'h1, 1'b1, 32'hA,        4'h8, 2'd2, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'hC,        4'h1, 1'b1, 32'hB,        4'h2, 2'd1, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'hC,        4'h1, 1'b1, 32'hC,        4'h1, 2'd1, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'hD,        4'h3, 1'b0, 32'hC,        4'h0, 2'd0, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h10,       4'hF, 1'b1, 32'h10,       4'hF, 2'd1, 1'b1};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h11,       4'hF, 1'b1, 32'h10,       4'hF, 2'd2, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 32'h12,       4'hF, 1'b0, 32'h10,       4'h0, 2'd0, 1'b1};
      tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 32'h10,       4'h0, 2'd0, 1'b1};
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].ev, tbl[i].alu, tbl[i].ctrl);
         mr = tbl[i].mr;
         flush = tbl[i].fl;
         tick();
         chk($sformatf("vec%0d", i), {87'b0, mv, m_alu, m_rs2, m_rd, m_ctrl, lvl, rdy},
             {87'b0, tbl[i].e_mv, tbl[i].e_alu, tbl[i].e_alu ^ 32'h5A5A_5A5A,
              tbl[i].e_alu[4:0], tbl[i].e_ctrl, tbl[i].e_lvl, tbl[i].e_rdy});
      end
      flush = 1'b0;
      chk("tbl_stall_cnt", {112'b0, cnt}, {112'b0, 16'd4});
      chk("tbl_small_cnt", {126'b0, s_cnt}, {126'b0, 2'd3});
      // stall counter from a clean reset
      rst = 1'b0;
      #2;
      rst = 1'b1;
      drive(1'b1, 32'h77, 4'h4);
      mr = 1'b0;
      tick();
      drive(1'b0, 32'h0, 4'h0);
      repeat (5) tick();
      chk("stall5", {112'b0, cnt}, {112'b0, 16'd5});
      chk("stall5_small", {126'b0, s_cnt}, {126'b0, 2'd3});
      tick();
      chk("stall6", {112'b0, cnt}, {112'b0, 16'd6});
      chk("stall6_small", {126'b0, s_cnt, lvl}, {124'b0, 2'd3, 2'd1});
      // async reset while full
      drive(1'b1, 32'h88, 4'h5);
      tick();
      chk("full_before_rst", {125'b0, lvl, rdy}, {125'b0, 2'd2, 1'b0});
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst", {95'b0, mv, m_alu, m_rs2, m_rd, m_ctrl, lvl, rdy, cnt},
          {95'b0, 1'b0, 32'h0, 32'h0, 5'h0, 4'h0, 2'd0, 1'b1, 16'd0});
      drive(1'b0, 32'h0, 4'h0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      // random traffic against a queue model
      m_cnt = 16'd0;
      for (int c = 0; c < 10000; c++) begin
         chk("rnd_ctl", {105'b0, mv, lvl, rdy, m_ctrl & {4{~mv}}, cnt},
             {105'b0, q.size() > 0, 2'(q.size()), q.size() < 2, 4'h0, m_cnt});
         if (q.size() > 0)
            chk("rnd_head", {55'b0, m_ctrl, m_rd, m_rs2, m_alu}, {55'b0, q[0]});
         drive($urandom_range(0, 3) != 0, $urandom, 4'($urandom));
         rs2 = $urandom;
         rd = 5'($urandom);
         mr = $urandom_range(0, 2) != 0;
         flush = $urandom_range(0, 31) == 0;
         pl = {ctrl, rd, rs2, alu};
         if (q.size() > 0 && !mr && m_cnt != 16'hFFFF) m_cnt++;
         if (flush) q.delete();
         else begin
            if (ev && q.size() < 2 && q.size() > 0 && mr) begin
               void'(q.pop_front());
               q.push_back(pl);
            end else if (q.size() > 0 && mr) void'(q.pop_front());
            else if (ev && q.size() < 2) q.push_back(pl);
         end
         tick();
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
